// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB bridge: FSM states, default
// bridge base, slave-index width helper and the peripheral map.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0200_0000;

    // CLINT sits in the first window; siblings follow in 4 KB steps.
    localparam int unsigned CLINT_IDX  = 0;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] SLV_STRIDE = 32'h0000_1000;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic [31:0] slv_base(input int unsigned idx);
        return CLINT_BASE + SLV_STRIDE * (idx - CLINT_IDX);
    endfunction

endpackage

// File: rtl/apb_bridge_if.sv
// Bundles the core request/response port and the APB bus of the bridge.
// The slave modport is the bridge's view; master is the core plus peripherals.
interface apb_bridge_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_SLV        = 4
);
    logic                      req_i;
    logic                      gnt_o;
    logic                      we_i;
    logic [31:0]               addr_i;
    logic [31:0]               wdata_i;
    logic                      rvalid_o;
    logic [31:0]               rdata_o;
    logic                      err_o;

    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic [NUM_SLV*32-1:0]     PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, PRDATA, PREADY, PSLVERR,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, PRDATA, PREADY, PSLVERR,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: hit on the bridge region, slave index and
// the matching one-hot select (all zero on a miss).
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_SLV        = 4,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    localparam int unsigned IDX_W         = clog2(NUM_SLV),
    localparam int unsigned IDX_BITS      = (IDX_W == 0) ? 1 : IDX_W
) (
    input  logic [31:0]         addr_i,
    output logic                hit_o,
    output logic [IDX_BITS-1:0] idx_o,
    output logic [NUM_SLV-1:0]  sel_o
);
    localparam int unsigned HI_LSB = IDX_W + APB_ADDR_WIDTH;

    // The in-window offset is irrelevant to the decode.
    logic unused_offset;
    assign unused_offset = ^addr_i[APB_ADDR_WIDTH-1:0];

    assign hit_o = (addr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);

    if (IDX_W == 0) begin : g_single
        assign idx_o = '0;
    end else begin : g_multi
        assign idx_o = addr_i[HI_LSB-1:APB_ADDR_WIDTH];
    end

    assign sel_o = hit_o ? (NUM_SLV'(1) << idx_o) : '0;

endmodule

// File: rtl/apb_bridge.sv
// Single-master bridge from the core request/grant port to APB: decode,
// SETUP/ACCESS sequencing, wait-state timeout and a one-cycle response strobe.
module apb_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_SLV        = 4,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned IDX_W         = clog2(NUM_SLV),
    localparam int unsigned IDX_BITS      = (IDX_W == 0) ? 1 : IDX_W
) (
    input logic         PCLK,
    input logic         PRESETn,
    apb_bridge_if.slave bus
);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                    state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [NUM_SLV-1:0]        psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      pwrite_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]               pwdata_q;
    logic [IDX_BITS-1:0]       idx_q;

    logic                      gnt;
    logic                      dec_hit;
    logic [IDX_BITS-1:0]       dec_idx;
    logic [NUM_SLV-1:0]        dec_sel;
    logic [31:0]               prdata_sel;

    apb_addr_decoder #(
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .NUM_SLV        (NUM_SLV),
        .BASE_ADDR      (BASE_ADDR)
    ) u_dec (
        .addr_i (bus.addr_i),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .sel_o  (dec_sel)
    );

    assign gnt        = bus.req_i & (state_q == IDLE);
    assign prdata_sel = bus.PRDATA[{idx_q, 5'b0} +: 32];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        psel_d    = '0;
        penable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    if (dec_hit) begin
                        state_d = SETUP;
                    end else begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.PREADY[idx_q]) begin
                    state_d = RESP;
                    rdata_d = pwrite_q ? '0 : prdata_sel;
                    err_d   = bus.PSLVERR[idx_q];
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // APB strobes are registered copies of the next state, so they
        // drop on the same edge that leaves ACCESS (including a timeout).
        if (state_d == SETUP) begin
            psel_d = dec_sel;
        end else if (state_d == ACCESS) begin
            psel_d    = psel_q;
            penable_d = 1'b1;
        end
        rvalid_d = (state_d == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Request fields are captured once at grant and held until the next grant.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            idx_q    <= '0;
        end else if (gnt) begin
            pwrite_q <= bus.we_i;
            paddr_q  <= bus.addr_i[APB_ADDR_WIDTH-1:0];
            pwdata_q <= bus.wdata_i;
            idx_q    <= dec_idx;
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;
    assign bus.PADDR    = paddr_q;
    assign bus.PWDATA   = pwdata_q;
    assign bus.PWRITE   = pwrite_q;
    assign bus.PSEL     = psel_q;
    assign bus.PENABLE  = penable_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Randomised scoreboard bench for apb_bridge with behavioural APB slaves and a
// window-level reference model of decode, latency, data and error behaviour.
module tb_apb_bridge;
    import apb_bridge_pkg::*;

    localparam int          AW   = 12;
    localparam int          NS   = 4;
    localparam int          TO   = 4;
    localparam logic [31:0] BASE = DEFAULT_BASE_ADDR;
    localparam logic [31:0] WIN  = 32'h0000_1000;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_bridge_if #(.APB_ADDR_WIDTH(AW), .NUM_SLV(NS)) bus ();

    apb_bridge #(
        .APB_ADDR_WIDTH (AW),
        .NUM_SLV        (NS),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            nacc;
        int            nsetup;
        logic [NS-1:0] sel;
        logic [AW-1:0] paddr;
        logic          we;
        logic [31:0]   wdata;
        int            t_acc;
    } exp_t;

    exp_t      exp_q[$];
    int        n_vec = 0;
    int        n_err = 0;
    int        cyc   = 0;
    bit [31:0] slv_mem [NS][4096];
    bit [31:0] ref_mem [NS][4096];
    int        cfg_wait [NS];
    bit        cfg_err  [NS];
    bit        cfg_hang [NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    // Behavioural slaves: selected slave readies after its configured number
    // of ACCESS cycles; everything else on the response bus is noise.
    initial begin
        int s_acc [NS];
        bus.PREADY  = '0;
        bus.PSLVERR = '0;
        bus.PRDATA  = '0;
        for (int i = 0; i < NS; i++) s_acc[i] = 0;
        forever begin
            @(negedge PCLK);
            for (int i = 0; i < NS; i++) begin
                if (bus.PSEL[i] && bus.PENABLE) begin
                    if (!cfg_hang[i] && s_acc[i] == cfg_wait[i]) begin
                        bus.PREADY[i]         = 1'b1;
                        bus.PSLVERR[i]        = cfg_err[i];
                        bus.PRDATA[i*32 +: 32] = slv_mem[i][bus.PADDR];
                        if (bus.PWRITE) slv_mem[i][bus.PADDR] = bus.PWDATA;
                    end else begin
                        bus.PREADY[i]         = 1'b0;
                        bus.PSLVERR[i]        = 1'($urandom_range(0, 1));
                        bus.PRDATA[i*32 +: 32] = $urandom;
                    end
                    s_acc[i]++;
                end else begin
                    s_acc[i]               = 0;
                    bus.PREADY[i]          = 1'($urandom_range(0, 1));
                    bus.PSLVERR[i]         = 1'($urandom_range(0, 1));
                    bus.PRDATA[i*32 +: 32] = $urandom;
                end
            end
        end
    end

    // Monitor: APB phase checks against the transaction in flight, then
    // response checks whenever rvalid_o is seen.
    initial begin
        exp_t x;
        int   mon_acc;
        int   mon_setup;
        mon_acc   = 0;
        mon_setup = 0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                mon_acc   = 0;
                mon_setup = 0;
            end else begin
                if (bus.PSEL != '0) begin
                    if (exp_q.size() == 0) begin
                        check("psel_without_request", bus.PSEL, 0);
                    end else begin
                        check("psel", bus.PSEL, exp_q[0].sel);
                        check("paddr", bus.PADDR, exp_q[0].paddr);
                        check("pwrite", bus.PWRITE, exp_q[0].we);
                        check("pwdata", bus.PWDATA, exp_q[0].wdata);
                        if (bus.PENABLE) mon_acc++;
                        else mon_setup++;
                    end
                end else if (bus.PENABLE) begin
                    check("penable_without_psel", 1, 0);
                end
                if (bus.rvalid_o) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_rvalid", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        check("rdata", bus.rdata_o, x.rdata);
                        check("err", bus.err_o, x.err);
                        check("latency", cyc - x.t_acc, x.lat);
                        check("access_cycles", mon_acc, x.nacc);
                        check("setup_cycles", mon_setup, x.nsetup);
                    end
                    mon_acc   = 0;
                    mon_setup = 0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int w, input bit e, input bit hang);
        exp_t          x;
        int            n;
        int            idx;
        logic [AW-1:0] pa;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wd;
        n = 0;
        @(negedge PCLK);
        while (!bus.gnt_o && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        if (!bus.gnt_o) begin
            check("grant_wait", 0, 1);
        end else begin
            pa      = addr[AW-1:0];
            x.t_acc = cyc;
            x.we    = we;
            x.wdata = wd;
            x.paddr = pa;
            if (addr < BASE || addr >= BASE + NS * WIN) begin
                x.rdata = '0; x.err = 1'b1; x.lat = 1; x.nacc = 0; x.nsetup = 0; x.sel = '0;
            end else begin
                idx           = int'((addr - BASE) / WIN);
                cfg_wait[idx] = w;
                cfg_err[idx]  = e;
                cfg_hang[idx] = hang;
                x.sel         = 4'b0001 << idx;
                x.nsetup      = 1;
                if (hang) begin
                    x.rdata = '0; x.err = 1'b1; x.lat = 2 + TO; x.nacc = TO;
                end else begin
                    x.rdata = we ? 32'h0 : ref_mem[idx][pa];
                    if (we) ref_mem[idx][pa] = wd;
                    x.err  = e;
                    x.lat  = 3 + w;
                    x.nacc = w + 1;
                end
            end
            exp_q.push_back(x);
        end
        @(posedge PCLK);
        #1;
        bus.req_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("response_wait", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        int          idx;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        for (int i = 0; i < NS; i++) begin
            cfg_wait[i] = 0;
            cfg_err[i]  = 1'b0;
            cfg_hang[i] = 1'b0;
            for (int j = 0; j < 4096; j++) begin
                slv_mem[i][j] = $urandom;
                ref_mem[i][j] = slv_mem[i][j];
            end
        end
        slv_mem[0][0] = 32'h1234_5678;
        ref_mem[0][0] = 32'h1234_5678;

        #12;
        check("rst_psel", bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_paddr", bus.PADDR, 0);
        check("rst_pwdata", bus.PWDATA, 0);
        check("rst_pwrite", bus.PWRITE, 0);
        check("rst_rvalid", bus.rvalid_o, 0);
        check("rst_rdata", bus.rdata_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_gnt", bus.gnt_o, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // Zero-wait read of mtime on CLINT
        issue(1'b0, 32'h0200_0000, 32'h0, 0, 1'b0, 1'b0);
        wait_idle();
        // mtimecmp write then read-back
        issue(1'b1, 32'h0200_0004, 32'h0000_0010, 0, 1'b0, 1'b0);
        wait_idle();
        issue(1'b0, 32'h0200_0004, 32'h0, 0, 1'b0, 1'b0);
        wait_idle();
        // Slave 2: three wait states then PSLVERR
        issue(1'b0, 32'h0200_2008, 32'h0, 3, 1'b1, 1'b0);
        wait_idle();
        // Decode miss
        issue(1'b0, 32'h0300_0000, 32'h0, 0, 1'b0, 1'b0);
        wait_idle();
        // Hung slave 1 then a normal follow-up on the same slave
        issue(1'b0, 32'h0200_1000, 32'h0, 0, 1'b0, 1'b1);
        wait_idle();
        issue(1'b0, 32'h0200_1004, 32'h0, 0, 1'b0, 1'b0);
        wait_idle();

        // Reset in the middle of a stalled access
        issue(1'b0, 32'h0200_1000, 32'h0, 0, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge PCLK);
            #1;
        end
        check("stall_penable", bus.PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("async_rst_psel", bus.PSEL, 0);
        check("async_rst_penable", bus.PENABLE, 0);
        exp_q.delete();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        check("post_rst_rdata", bus.rdata_o, 0);
        check("post_rst_err", bus.err_o, 0);
        issue(1'b0, 32'h0200_0000, 32'h0, 0, 1'b0, 1'b0);
        wait_idle();

        // Random traffic, often back-to-back with req_i held during busy states
        for (int k = 0; k < 300; k++) begin
            idx = $urandom_range(0, NS - 1);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = slv_base(idx) + 32'($urandom_range(0, 15) * 4);
            issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
